seq_div16: RTL



---
 rtl/seq_div16.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/seq_div16.sv
// seq_div16: iterative radix-2 restoring divider for unsigned operands.
// Produces quotient and remainder over WIDTH cycles, one trial subtract per
// cycle, behind a start/busy/done handshake. Division by zero finishes
// immediately with quotient all ones, remainder = dividend and a flag.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        request, accepted in IDLE or FIN
//   dividend     numerator, captured on accepted start
//   divisor      denominator, captured on accepted start
//   busy         high while an iteration is in flight
//   done         one-cycle pulse, results valid from this cycle
//   quotient     result, held until the next FIN
//   remainder    result, held until the next FIN
//   div_by_zero  divisor==0 flag, held like the results
module seq_div16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e           state_q, state_d;
  // The partial remainder is always below the divisor after a step, so its
  // top bit is never stored; the WIDTH+1-bit form exists only in the subtract.
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;

  assign accept = start && (state_q != RUN);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  // One restoring step: shift in the next dividend bit, trial-subtract.
  assign r_sh   = {r_q, q_q[WIDTH-1]};
  assign t      = r_sh - {1'b0, dvs_q};
  assign r_step = t[WIDTH] ? r_sh[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_step = {q_q[WIDTH-2:0], ~t[WIDTH]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = (divisor == '0) ? FIN : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          state_d = FIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic; outputs are registered from next-state values
  // so busy/done line up with the state they describe.
  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
    if (accept) begin
      r_d   = '0;
      q_d   = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      if (divisor == '0) begin
        quo_d = '1;
        rem_d = dividend;
        dbz_d = 1'b1;
      end
    end else if (state_q == RUN) begin
      r_d   = r_step;
      q_d   = q_step;
      cnt_d = cnt_q + CW'(1);
      if (last) begin
        quo_d = q_step;
        rem_d = r_step;
        dbz_d = 1'b0;
      end
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
